// File: rtl/pipe_run_ctrl_pkg.sv
// Shared types for the pipeline run-control sequencer: FSM states, halt causes
// and the opcode that marks a halt instruction.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } run_state_t;

    typedef enum logic [1:0] {
        C_NONE = 2'd0,
        C_REQ  = 2'd1,
        C_BP   = 2'd2,
        C_HALT = 2'd3
    } halt_cause_t;

    localparam logic [6:0] HALT_OPCODE = 7'h7F;

endpackage

// File: rtl/pipe_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment and the
// count sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run-control sequencer for the 5-stage pipeline: start, single-step, halt on
// request/breakpoint/halt instruction, drain the back end, then park in HALTED.
module pipe_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int PC_W      = 9,
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  if_pc,
    input  logic             halt_seen,
    input  logic             id_issue,
    input  logic             clr_cnt,
    output logic             pc_hold,
    output logic             bubble_id,
    output logic             running,
    output logic             halted,
    output logic [2:0]       state,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

    run_state_t  state_q, state_d;
    halt_cause_t cause_q, cause_d;
    logic [DW-1:0] drain_q, drain_d;
    logic bp_mask_q, bp_mask_d;
    logic term_q, term_d;

    logic        bp_hit;
    logic        active;
    halt_cause_t trig;
    halt_cause_t trig_eff;

    assign active = (state_q == RUN) || (state_q == STEP);
    assign bp_hit = bp_en && (if_pc == bp_addr) && !bp_mask_q;

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        drain_d   = drain_q;
        bp_mask_d = bp_mask_q;
        term_d    = term_q;

        if (halt_seen)     trig = C_HALT;
        else if (bp_hit)   trig = C_BP;
        else if (halt_req) trig = C_REQ;
        else               trig = C_NONE;

        // A single step completes as soon as its one instruction issues.
        trig_eff = trig;
        if ((state_q == STEP) && (trig == C_NONE) && id_issue) begin
            trig_eff = C_REQ;
        end

        // The mask only suppresses the breakpoint we just resumed from.
        if (bp_mask_q && (if_pc != bp_addr)) begin
            bp_mask_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (step)       state_d = STEP;
                else if (start) state_d = RUN;
            end
            RUN, STEP: begin
                if (trig_eff != C_NONE) begin
                    state_d = DRAIN;
                    cause_d = trig_eff;
                    drain_d = DRAIN_LOAD;
                    if (trig_eff == C_HALT) term_d = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == '0) state_d = HALTED;
                else               drain_d = drain_q - {{(DW-1){1'b0}}, 1'b1};
            end
            HALTED: begin
                if (!term_q && (step || start)) begin
                    state_d = step ? STEP : RUN;
                    if (cause_q == C_BP) bp_mask_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cause_q   <= C_NONE;
            drain_q   <= '0;
            bp_mask_q <= 1'b0;
            term_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            drain_q   <= drain_d;
            bp_mask_q <= bp_mask_d;
            term_q    <= term_d;
        end
    end

    // halt_seen bubbles ID immediately so the halt word never reaches EX.
    assign pc_hold    = !active;
    assign bubble_id  = !active || halt_seen;
    assign running    = active;
    assign halted     = (state_q == HALTED);
    assign state      = state_q;
    assign halt_cause = cause_q;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (active),
        .q     (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_issue_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (active && id_issue),
        .q     (issue_cnt)
    );

endmodule
